button_event_detector: RTL and testbench
========================================

# button_event_detector

Converts the debounced, active-low push-button level from the debouncer into single-cycle control events for the serial-bus top level: press, short release and long hold. It also keeps a running press count for the board display. It sits directly downstream of the debouncer and upstream of the master/slave start logic.

## Interface
- `LONG_PRESS_CYCLES`, default 16: held cycles (counted in PRESSED) before a press is classed as long; legal range ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer depth on `btn_in`; legal range ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high (one clock; reset asynchronous and active-high).
- `btn_in`  in  1  debounced button level, 0 = pressed, 1 = released.
- `press_pulse`  out  1  one-cycle pulse on each accepted press.
- `short_pulse`  out  1  one-cycle pulse on release before the long threshold.
- `long_pulse`  out  1  one-cycle pulse when hold reaches `LONG_PRESS_CYCLES`.
- `held`  out  1  high while FSM is in PRESSED or LONG.
- `press_count`  out  8  number of accepted presses, modulo 256.

## Operation
- `btn_in` passes through `SYNC_STAGES` flops, which reset to 1 (released). The FSM sees only the last stage, `btn_s`.
- FSM states and transitions:
  - IDLE → PRESSED when `btn_s == 0`. Asserts `press_pulse`, increments `press_count`, clears `hold_cnt`.
  - PRESSED with `btn_s == 1` → IDLE, asserting `short_pulse`.
  - PRESSED with `btn_s == 0`: `hold_cnt` increments. When `hold_cnt == LONG_PRESS_CYCLES-1`, go to LONG and assert `long_pulse`.
  - LONG with `btn_s == 1` → IDLE, no pulse. LONG otherwise holds.
- `hold_cnt` width is `$clog2(LONG_PRESS_CYCLES)`. It saturates and never wraps.
- `press_count` wraps from 255 to 0 with no flag.
- All outputs are registered. At most one of the three pulses is high in any cycle.
- Release and the threshold cycle can coincide (`btn_s` returns to 1 in the cycle `hold_cnt` would reach threshold). Release wins: `short_pulse` only, no `long_pulse`.
- A press after release needs `btn_s` seen at 1 for at least one cycle (a pass through IDLE). There is no re-trigger while held.

## Timing
- Reset values: `press_pulse`, `short_pulse`, `long_pulse` and `held` are 0; `press_count` is 0; FSM is in IDLE; sync flops are 1.
- Press latency: if `btn_in` is 0 at rising edge k, `press_pulse` and `held` are high in the cycle after edge k+`SYNC_STAGES`. With the default depth this is 3 edges.
- Short release latency: also `SYNC_STAGES`+1 edges after `btn_in` returns to 1. `held` falls in the same cycle `short_pulse` rises.
- Long threshold: `long_pulse` rises exactly `LONG_PRESS_CYCLES` cycles after `press_pulse`, for a continuous hold.
- Reset mid-operation: all outputs clear asynchronously and the FSM returns to IDLE. If the button is still held after `rst` deasserts, a fresh press is detected with normal latency, because the sync flops reset to released.
- Pulses are exactly one cycle wide. There are no handshakes; consumers must sample every cycle.

## Configuration
- Macro: `BUTTON_LONG_PRESS_EN`.
- Defined: long-press classification exactly as above.
- Undefined:
  - LONG state and `hold_cnt` are removed.
  - `long_pulse` is tied to 0.
  - Every release from PRESSED produces `short_pulse`, regardless of hold duration.
  - `LONG_PRESS_CYCLES` is ignored.

## Structure
- Shared package `button_event_pkg`:
  - state enum typedef `btn_state_t` (IDLE, PRESSED, LONG);
  - `PRESS_COUNT_W = 8`.
- Sub-module `btn_synchronizer`: a parameterised `SYNC_STAGES` flop chain with reset-to-1, reused by the other button inputs on the board top.

## Test plan
- Defaults, `btn_in` low for 5 cycles then high: `press_pulse` 3 edges after the falling input, `short_pulse` 3 edges after release, `long_pulse` never, `press_count` = 1.
- Hold for 30 cycles: `long_pulse` exactly 16 cycles after `press_pulse`, no `short_pulse` on release, `held` high throughout.
- Release aligned so `btn_s` rises in the threshold cycle: `short_pulse` only, `long_pulse` stays 0.
- 257 short presses: `press_count` reads 1 (wrapped), and exactly 257 `press_pulse` events occur.
- Assert `rst` mid-hold while in LONG: outputs 0 immediately. After deassert with the button still low, `press_pulse` follows 3 edges later and `press_count` = 1.
- `BUTTON_LONG_PRESS_EN` undefined, 30-cycle hold: `long_pulse` stays 0 and `short_pulse` fires on release.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared types and constants for the push-button event path.
// Consumed by button_event_detector and the board top.
package button_event_pkg;

    localparam int unsigned PRESS_COUNT_W = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StLong    = 2'd2
    } btn_state_t;

    function automatic logic state_is_held(input btn_state_t s);
        return (s == StPressed) || (s == StLong);
    endfunction

endpackage

// File: rtl/btn_synchronizer.sv
// Reset-to-released flop chain for asynchronous, active-low button levels.
// Shared by every button input on the board top.
module btn_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("btn_synchronizer: SYNC_STAGES must be at least 2");
    end

    // Reset to all ones so a held button looks released until sampled afresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_event_detector.sv
// Turns the debounced active-low button level into press / short / long event pulses
// plus a wrapping press count. Long-press classification is built only with BUTTON_LONG_PRESS_EN.
module button_event_detector
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = 16,
    parameter int unsigned SYNC_STAGES       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_in,
    output logic                     press_pulse,
    output logic                     short_pulse,
    output logic                     long_pulse,
    output logic                     held,
    output logic [PRESS_COUNT_W-1:0] press_count
);

    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long
        $error("button_event_detector: LONG_PRESS_CYCLES must be at least 2");
    end

    logic btn_s;

    btn_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (btn_s)
    );

    btn_state_t               state_q, state_d;
    logic                     press_q, press_d;
    logic                     short_q, short_d;
    logic                     held_q, held_d;
    logic [PRESS_COUNT_W-1:0] count_q, count_d;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned    HoldW    = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);

    logic             long_q, long_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_done;

    assign hold_done = (hold_cnt_q == HoldLast);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a release always takes priority over the threshold.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!btn_s) begin
                    state_d = StPressed;
                end
            end
            StPressed: begin
                if (btn_s) begin
                    state_d = StIdle;
`ifdef BUTTON_LONG_PRESS_EN
                end else if (hold_done) begin
                    state_d = StLong;
`endif
                end
            end
            StLong: begin
                if (btn_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next values, registered below
    always_comb begin
        press_d = (state_q == StIdle) && (state_d == StPressed);
        short_d = (state_q == StPressed) && (state_d == StIdle);
        held_d  = state_is_held(state_d);
        count_d = press_d ? count_q + 1'b1 : count_q;
`ifdef BUTTON_LONG_PRESS_EN
        long_d     = (state_q == StPressed) && (state_d == StLong);
        hold_cnt_d = hold_cnt_q;
        if (press_d) begin
            hold_cnt_d = '0;
        end else if ((state_q == StPressed) && !btn_s && !hold_done) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_q <= 1'b0;
            short_q <= 1'b0;
            held_q  <= 1'b0;
            count_q <= '0;
        end else begin
            press_q <= press_d;
            short_q <= short_d;
            held_q  <= held_d;
            count_q <= count_d;
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            long_q     <= long_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

    assign press_pulse = press_q;
    assign short_pulse = short_q;
    assign held        = held_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Self-checking bench for button_event_detector: vector table, corner-case sequences
// and random runs against an event-level model; follows BUTTON_LONG_PRESS_EN like the DUT.
module tb_button_event_detector;

    localparam int unsigned L = 16;
    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b1;
    logic       press_pulse, short_pulse, long_pulse, held;
    logic [7:0] press_count;

    int checks = 0;
    int passes = 0;
    int t = 0;

    always #5 clk = ~clk;

    button_event_detector #(
        .LONG_PRESS_CYCLES (L),
        .SYNC_STAGES       (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .press_pulse (press_pulse),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .held        (held),
        .press_count (press_count)
    );

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, t);
    endfunction

    // Event-level model: inputs reach the FSM S edges late; a press is timestamped
    // and classed long once L edges have elapsed since it.
    bit m_line[$];
    bit m_active, m_long;
    int m_press_t, m_count;
    bit e_press, e_short, e_long, e_held;

    function automatic void model_reset();
        m_line.delete();
        for (int i = 0; i < S; i++) m_line.push_back(1'b1);
        m_active = 0; m_long = 0; m_count = 0; m_press_t = 0;
        e_press = 0; e_short = 0; e_long = 0; e_held = 0;
    endfunction

    function automatic void model_edge(input bit b);
        bit s;
        m_line.push_back(b);
        s = m_line.pop_front();
        e_press = 0; e_short = 0; e_long = 0;
        if (!m_active) begin
            if (!s) begin
                m_active = 1; m_long = 0; m_press_t = t; e_press = 1;
                m_count = (m_count + 1) % 256;
            end
        end else if (s) begin
            m_active = 0;
            if (!m_long) e_short = 1;
`ifdef BUTTON_LONG_PRESS_EN
        end else if (!m_long && (t - m_press_t == L)) begin
            m_long = 1; e_long = 1;
`endif
        end
        e_held = m_active;
    endfunction

    function automatic void compare_model();
        check("press_pulse", press_pulse, e_press);
        check("short_pulse", short_pulse, e_short);
        check("long_pulse", long_pulse, e_long);
        check("held", held, e_held);
        check("press_count", press_count, m_count);
        check("one_pulse_max", (int'(press_pulse) + int'(short_pulse) + int'(long_pulse)) <= 1, 1);
    endfunction

    // Event bookkeeping for the hand-written sequences
    int ev_np, ev_ns, ev_nl, ev_tp, ev_ts, ev_tl, ev_held;

    function automatic void clear_ev();
        ev_np = 0; ev_ns = 0; ev_nl = 0; ev_tp = -1; ev_ts = -1; ev_tl = -1; ev_held = 0;
    endfunction

    task automatic tick(input logic b);
        btn_in = b;
        @(posedge clk);
        t++;
        model_edge(b);
        #1;
        if (press_pulse) begin ev_np++; if (ev_tp < 0) ev_tp = t; end
        if (short_pulse) begin ev_ns++; if (ev_ts < 0) ev_ts = t; end
        if (long_pulse)  begin ev_nl++; if (ev_tl < 0) ev_tl = t; end
        if (held) ev_held++;
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            tick(b);
            compare_model();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        btn_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_ev();
        t = 0;
    endtask

    typedef struct packed {
        logic       btn;
        logic       press;
        logic       shrt;
        logic       lng;
        logic       hld;
        logic [7:0] count;
    } vec_t;

    function automatic vec_t mk(input logic b, input logic p, input logic s, input logic l,
                                input logic h, input logic [7:0] c);
        return '{btn: b, press: p, shrt: s, lng: l, hld: h, count: c};
    endfunction

    vec_t vecs[15];

    initial begin
        logic lvl;
        // One row per edge: btn driven before the edge, outputs expected after it.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 1, 1);
        vecs[3]  = mk(0, 0, 0, 0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 0, 1, 1);
        vecs[5]  = mk(1, 0, 0, 0, 1, 1);
        vecs[6]  = mk(1, 0, 0, 0, 1, 1);
        vecs[7]  = mk(1, 0, 1, 0, 0, 1);
        vecs[8]  = mk(1, 0, 0, 0, 0, 1);
        vecs[9]  = mk(1, 0, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 1);
        vecs[11] = mk(1, 0, 0, 0, 0, 1);
        vecs[12] = mk(1, 1, 0, 0, 1, 2);
        vecs[13] = mk(1, 0, 1, 0, 0, 2);
        vecs[14] = mk(1, 0, 0, 0, 0, 2);

        // Reset values while rst is held
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_press", press_pulse, 0);
        check("reset_short", short_pulse, 0);
        check("reset_long", long_pulse, 0);
        check("reset_held", held, 0);
        check("reset_count", press_count, 0);

        // Vector table: short press, then a single-cycle tap
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].btn);
            check($sformatf("vec%0d", i),
                  int'({press_pulse, short_pulse, long_pulse, held, press_count}),
                  int'({vecs[i].press, vecs[i].shrt, vecs[i].lng, vecs[i].hld, vecs[i].count}));
        end

        // 30-cycle hold
        apply_reset();
        run(1'b0, 30);
        run(1'b1, 8);
        check("hold30_press_edge", ev_tp, 3);
        check("hold30_presses", ev_np, 1);
        check("hold30_held_cycles", ev_held, 30);
`ifdef BUTTON_LONG_PRESS_EN
        check("hold30_long_delay", ev_tl - ev_tp, L);
        check("hold30_longs", ev_nl, 1);
        check("hold30_shorts", ev_ns, 0);
`else
        check("hold30_longs", ev_nl, 0);
        check("hold30_short_edge", ev_ts, 33);
`endif

        // Release lands exactly on the threshold edge: short wins
        apply_reset();
        run(1'b0, 16);
        run(1'b1, 6);
        check("thresh_short_edge", ev_ts, 19);
        check("thresh_longs", ev_nl, 0);

        // One more held edge crosses the threshold
        apply_reset();
        run(1'b0, 17);
        run(1'b1, 6);
`ifdef BUTTON_LONG_PRESS_EN
        check("thresh1_long_edge", ev_tl, 19);
        check("thresh1_shorts", ev_ns, 0);
`else
        check("thresh1_short_edge", ev_ts, 20);
        check("thresh1_longs", ev_nl, 0);
`endif

        // 257 short presses wrap the counter
        apply_reset();
        for (int i = 0; i < 257; i++) begin
            run(1'b0, 1);
            run(1'b1, 2);
        end
        run(1'b1, 4);
        check("wrap_presses", ev_np, 257);
        check("wrap_count", press_count, 1);

        // Reset mid-hold with the button still down
        apply_reset();
        run(1'b0, 25);
        check("midrst_held_before", held, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_press", press_pulse, 0);
        check("midrst_short", short_pulse, 0);
        check("midrst_long", long_pulse, 0);
        check("midrst_held", held, 0);
        check("midrst_count", press_count, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_ev();
        t = 0;
        run(1'b0, 6);
        check("midrst_repress_edge", ev_tp, 3);
        check("midrst_repress_count", press_count, 1);

        // Random run lengths against the model
        apply_reset();
        lvl = 1'b0;
        while (t < 1500) begin
            run(lvl, int'($urandom_range(1, 40)));
            lvl = ~lvl;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
